// File: rtl/axi_bram_pkg.sv
// axi_bram_pkg: shared types and helpers for the AXI4 block-RAM slave.
//   burst_e    : AXI burst encodings (FIXED/INCR/WRAP)
//   OKAY/SLVERR: response codes
//   w_state_e / r_state_e : write and read FSM states
//   next_addr  : AXI4 beat-to-beat address update
//   burst_err  : whole-burst legality check
// Optional feature macro: AXI_BRAM_WRAP_EN (WRAP burst support).
package axi_bram_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_BURST} r_state_e;

  // Address of the beat following addr. INCR realigns to the transfer size
  // so an unaligned start continues on aligned addresses.
  function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                            input logic [15:0] len,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    logic [63:0] step;
    logic [63:0] aligned;
    step      = 64'd1 << size;
    aligned   = (addr >> size) << size;
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = aligned + step;
`ifdef AXI_BRAM_WRAP_EN
      BURST_WRAP: begin
        logic [63:0] mask;
        mask      = ((64'(len) + 64'd1) << size) - 64'd1;
        next_addr = (addr & ~mask) | ((addr + step) & mask);
      end
`endif
      default: next_addr = addr;
    endcase
  endfunction

  // Conditions that fail every beat of a burst.
  function automatic logic burst_err(input logic [15:0] len,
                                     input logic [2:0]  size,
                                     input logic [1:0]  burst,
                                     input logic [2:0]  max_size);
    burst_err = (size > max_size) || (burst == 2'b11);
`ifdef AXI_BRAM_WRAP_EN
    if (burst == BURST_WRAP &&
        !(len == 16'd1 || len == 16'd3 || len == 16'd7 || len == 16'd15))
      burst_err = 1'b1;
`else
    if (burst == BURST_WRAP && len == len)
      burst_err = 1'b1;
`endif
  endfunction

endpackage

// File: rtl/axi_bram_if.sv
// axi_bram_if: AXI4 bus bundle between a master and axi_bram_slave.
//   AW/W/B write channels, AR/R read channels.
//   modport master : drives addresses, write data, bready/rready
//   modport slave  : drives ready signals, B and R responses
interface axi_bram_if #(
  parameter int ID_BITS    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_BITS   = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ID_BITS-1:0]      awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [LEN_BITS-1:0]     awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_BITS-1:0]      bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_BITS-1:0]      arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [LEN_BITS-1:0]     arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_BITS-1:0]      rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_bram_mem.sv
// axi_bram_mem: simple dual-port RAM, byte write enables, registered
// read-first output (a read of the word being written returns old data).
//   clk_i : clock
//   we    : per-byte write enable      waddr/wdata : write port
//   re    : read enable                raddr/rdata : read port (1-cycle)
module axi_bram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  localparam int NB        = DATA_WIDTH / 8,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic [NB-1:0]         we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++)
      if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi_bram_slave.sv
// axi_bram_slave: AXI4 slave over a byte-enabled read-first block RAM.
//   clk_i : clock (rising edge)      rst_i : synchronous active-high reset
//   s_axi : AXI4 slave port (axi_bram_if.slave)
// One outstanding transaction per direction; read and write run in parallel.
// Read pipeline: p0 address register, p1 RAM output, p2 2-entry skid FIFO.
// Optional feature macro: AXI_BRAM_WRAP_EN (WRAP bursts; otherwise SLVERR).
module axi_bram_slave
  import axi_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_BITS    = 4,
  parameter int LEN_BITS   = 8,
  parameter int DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic       clk_i,
  input logic       rst_i,
  axi_bram_if.slave s_axi
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int ASIZE = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(ASIZE);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (off >> ASIZE) < ADDR_WIDTH'(DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> ASIZE);
  endfunction

  // Holds the ready outputs low for the first cycle after reset releases.
  logic live;
  always_ff @(posedge clk_i) live <= !rst_i;

  logic [NB-1:0]         mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [ADDR_WIDTH-1:0] aw_addr;

  axi_bram_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk_i (clk_i),
    .we    (mem_we),
    .waddr (word_idx(aw_addr)),
    .wdata (s_axi.wdata),
    .re    (issue),
    .raddr (word_idx(ar_addr)),
    .rdata (mem_rdata)
  );

  // ---------------- write channel ----------------
  w_state_e            w_state, w_next;
  logic [ID_BITS-1:0]  aw_id;
  logic [LEN_BITS-1:0] aw_len, w_cnt;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                w_berr, w_err, w_beat_ok, aw_hs, w_hs;

  assign aw_hs     = s_axi.awready && s_axi.awvalid;
  assign w_hs      = s_axi.wready && s_axi.wvalid;
  assign w_beat_ok = !w_berr && in_range(aw_addr);
  assign mem_we    = (w_hs && w_beat_ok) ? s_axi.wstrb : '0;

  always_comb begin
    w_next        = w_state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    s_axi.bid     = '0;
    s_axi.bresp   = OKAY;
    case (w_state)
      W_IDLE: begin
        s_axi.awready = live;
        if (live && s_axi.awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid && w_cnt == aw_len) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        s_axi.bid    = aw_id;
        s_axi.bresp  = w_err ? SLVERR : OKAY;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_cnt <= '0;
        w_err <= 1'b0;
      end else if (w_hs) begin
        w_cnt <= w_cnt + 1'b1;
        if (!w_beat_ok || (s_axi.wlast != (w_cnt == aw_len))) w_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_hs) begin
      aw_id    <= s_axi.awid;
      aw_addr  <= s_axi.awaddr;
      aw_len   <= s_axi.awlen;
      aw_size  <= s_axi.awsize;
      aw_burst <= s_axi.awburst;
      w_berr   <= burst_err(16'(s_axi.awlen), s_axi.awsize, s_axi.awburst, MAX_SIZE);
    end else if (w_hs) begin
      aw_addr <= ADDR_WIDTH'(next_addr(64'(aw_addr), 16'(aw_len), aw_size, aw_burst));
    end
  end

  // ---------------- read channel ----------------
  r_state_e            r_state, r_next;
  logic [ID_BITS-1:0]  ar_id;
  logic [LEN_BITS-1:0] ar_len, iss_cnt;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                r_berr, iss_done, ar_hs;
  logic                vld_p1, err_p1, last_p1;
  logic [DATA_WIDTH+2:0] beat_p1, head;
  logic [DATA_WIDTH+2:0] skid_p2 [2];
  logic [1:0]          skid_cnt;
  logic                rd_ptr, wr_ptr, skid_push, skid_pop, r_vld, r_pop;
  logic [2:0]          occ;

  assign ar_hs   = s_axi.arready && s_axi.arvalid;
  assign beat_p1 = {err_p1 ? SLVERR : OKAY, last_p1,
                    err_p1 ? {DATA_WIDTH{1'b0}} : mem_rdata};

  // The FIFO head is always older than the beat sitting in the RAM register.
  assign r_vld = (skid_cnt != 2'd0) || vld_p1;
  assign head  = (skid_cnt != 2'd0) ? skid_p2[rd_ptr] : (vld_p1 ? beat_p1 : '0);
  assign r_pop = r_vld && s_axi.rready;

  assign s_axi.rvalid = r_vld;
  assign s_axi.rresp  = head[DATA_WIDTH+2 -: 2];
  assign s_axi.rlast  = head[DATA_WIDTH];
  assign s_axi.rdata  = head[DATA_WIDTH-1:0];
  assign s_axi.rid    = r_vld ? ar_id : '0;

  // A returning beat bypasses the FIFO only when it is empty and the master
  // takes it straight away.
  assign skid_pop  = (skid_cnt != 2'd0) && s_axi.rready;
  assign skid_push = vld_p1 && !((skid_cnt == 2'd0) && s_axi.rready);

  // Entries still held after this cycle; a new read may only be issued when
  // at most one remains, so its data always finds a free FIFO slot.
  assign occ   = {1'b0, skid_cnt} + {2'b00, vld_p1} - {2'b00, r_pop};
  assign issue = (r_state == R_BURST) && !iss_done && (occ <= 3'd1);

  always_comb begin
    r_next        = r_state;
    s_axi.arready = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi.arready = live;
        if (live && s_axi.arvalid) r_next = R_BURST;
      end
      R_BURST: if (r_pop && s_axi.rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= R_IDLE;
      iss_cnt  <= '0;
      iss_done <= 1'b0;
      vld_p1   <= 1'b0;
      skid_cnt <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        iss_cnt  <= '0;
        iss_done <= 1'b0;
      end else if (issue) begin
        iss_cnt <= iss_cnt + 1'b1;
        if (iss_cnt == ar_len) iss_done <= 1'b1;
      end
      vld_p1 <= issue;
      if (skid_push) wr_ptr <= ~wr_ptr;
      if (skid_pop)  rd_ptr <= ~rd_ptr;
      skid_cnt <= skid_cnt + {1'b0, skid_push} - {1'b0, skid_pop};
    end
  end

  // p0: burst address register
  always_ff @(posedge clk_i) begin
    if (ar_hs) begin
      ar_id    <= s_axi.arid;
      ar_addr  <= s_axi.araddr;
      ar_len   <= s_axi.arlen;
      ar_size  <= s_axi.arsize;
      ar_burst <= s_axi.arburst;
      r_berr   <= burst_err(16'(s_axi.arlen), s_axi.arsize, s_axi.arburst, MAX_SIZE);
    end else if (issue) begin
      ar_addr <= ADDR_WIDTH'(next_addr(64'(ar_addr), 16'(ar_len), ar_size, ar_burst));
    end
  end

  // p1: RAM output stage attributes
  always_ff @(posedge clk_i) begin
    if (issue) begin
      err_p1  <= r_berr || !in_range(ar_addr);
      last_p1 <= (iss_cnt == ar_len);
    end
  end

  // p2: skid FIFO storage
  always_ff @(posedge clk_i) begin
    if (skid_push) skid_p2[wr_ptr] <= beat_p1;
  end
endmodule

// File: tb/tb_axi_bram_slave.sv
// tb_axi_bram_slave: directed self-checking bench for axi_bram_slave
// (DEPTH=256, BASE_ADDR=0x1000_0000, 32-bit data).
module tb_axi_bram_slave;
  import axi_bram_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_bram_if #(.ID_BITS(4), .ADDR_WIDTH(32), .LEN_BITS(8), .DATA_WIDTH(32)) bus ();

  axi_bram_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_BITS(4), .LEN_BITS(8),
    .DEPTH(256), .BASE_ADDR(BASE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .s_axi (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wbuf [16];
  logic [31:0] rdat [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  int          rcyc [16];
  int          stall_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.awid = 4'h5; bus.awaddr = addr; bus.awlen = 8'(len);
    bus.awsize = 3'd2; bus.awburst = burst; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("aw_timeout", 64'(n), 0);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.wdata = wbuf[i]; bus.wstrb = strb; bus.wlast = (i == len); bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("w_timeout", 64'(n), 0);
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
    chk("b_latency", 64'(n), 0);
    chk("bid", 64'(bus.bid), 64'h5);
    resp = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input bit toggle);
    int n, cyc, beat;
    logic stalled;
    logic [31:0] held;
    @(negedge clk);
    bus.arid = 4'h9; bus.araddr = addr; bus.arlen = 8'(len);
    bus.arsize = 3'd2; bus.arburst = burst; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("ar_timeout", 64'(n), 0);
    @(negedge clk);
    bus.arvalid = 1'b0;
    cyc = 0; beat = 0; stalled = 1'b0; held = '0; stall_bad = 0;
    while (beat <= len && cyc < 200) begin
      bus.rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled && (!bus.rvalid || bus.rdata !== held)) stall_bad++;
      stalled = 1'b0;
      if (bus.rvalid) begin
        if (bus.rready) begin
          rdat[beat] = bus.rdata; rrsp[beat] = bus.rresp;
          rlst[beat] = bus.rlast; rcyc[beat] = cyc;
          if (bus.rid !== 4'h9) stall_bad++;
          beat++;
        end else begin
          stalled = 1'b1; held = bus.rdata;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.rready = 1'b0;
    if (beat <= len) chk("r_timeout", 64'(beat), 64'(len + 1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp;
    int n, beat;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(bus.awready), 0);
    chk("rst_wready",  64'(bus.wready), 0);
    chk("rst_bvalid",  64'(bus.bvalid), 0);
    chk("rst_arready", 64'(bus.arready), 0);
    chk("rst_rvalid",  64'(bus.rvalid), 0);
    chk("rst_rlast",   64'(bus.rlast), 0);
    chk("rst_rdata",   64'(bus.rdata), 0);
    chk("rst_bresp",   64'(bus.bresp), 0);
    rst = 1'b0;
    chk("rel_awready_low", 64'(bus.awready), 0);
    @(negedge clk);
    chk("rel_awready", 64'(bus.awready), 1);
    chk("rel_arready", 64'(bus.arready), 1);

    // INCR write/read, len=3
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
    wr_burst(BASE + 32'h10, 3, BURST_INCR, 4'hF, resp);
    chk("incr_bresp", 64'(resp), 64'(OKAY));
    rd_burst(BASE + 32'h10, 3, BURST_INCR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr_d%0d", i), 64'(rdat[i]), 64'(32'hA0 + i));
      chk($sformatf("incr_last%0d", i), 64'(rlst[i]), 64'(i == 3));
      chk($sformatf("incr_resp%0d", i), 64'(rrsp[i]), 64'(OKAY));
    end
    chk("rd_first_latency", 64'(rcyc[0]), 1);
    chk("rd_rid", 64'(stall_bad), 0);

    // Byte strobes
    wbuf[0] = 32'hFFFF_FFFF;
    wr_burst(BASE + 32'h40, 0, BURST_INCR, 4'hF, resp);
    wbuf[0] = 32'h1122_3344;
    wr_burst(BASE + 32'h40, 0, BURST_INCR, 4'b0101, resp);
    rd_burst(BASE + 32'h40, 0, BURST_INCR, 1'b0);
    chk("strb_data", 64'(rdat[0]), 64'h FF22_FF44);
    chk("strb_last", 64'(rlst[0]), 1);

    // WRAP len=3 at 0x18
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + i;
    wr_burst(BASE + 32'h18, 3, BURST_WRAP, 4'hF, resp);
    rd_burst(BASE + 32'h10, 3, BURST_INCR, 1'b0);
`ifdef AXI_BRAM_WRAP_EN
    chk("wrap_bresp", 64'(resp), 64'(OKAY));
    chk("wrap_w10", 64'(rdat[0]), 64'hB2);
    chk("wrap_w14", 64'(rdat[1]), 64'hB3);
    chk("wrap_w18", 64'(rdat[2]), 64'hB0);
    chk("wrap_w1c", 64'(rdat[3]), 64'hB1);
    rd_burst(BASE + 32'h18, 3, BURST_WRAP, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_rd%0d", i), 64'(rdat[i]), 64'(32'hB0 + i));
`else
    chk("wrap_bresp", 64'(resp), 64'(SLVERR));
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_keep%0d", i), 64'(rdat[i]), 64'(32'hA0 + i));
    rd_burst(BASE + 32'h18, 3, BURST_WRAP, 1'b0);
    chk("wrap_rresp", 64'(rrsp[0]), 64'(SLVERR));
    chk("wrap_rdata", 64'(rdat[1]), 0);
`endif

    // len=7 with back-pressure, then full rate
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0 + i;
    wr_burst(BASE + 32'h80, 7, BURST_INCR, 4'hF, resp);
    chk("c_bresp", 64'(resp), 64'(OKAY));
    rd_burst(BASE + 32'h80, 7, BURST_INCR, 1'b1);
    for (int i = 0; i < 8; i++) chk($sformatf("stall_d%0d", i), 64'(rdat[i]), 64'(32'hC0 + i));
    chk("stall_stable", 64'(stall_bad), 0);
    chk("stall_last", 64'(rlst[7]), 1);
    rd_burst(BASE + 32'h80, 7, BURST_INCR, 1'b0);
    chk("full_rate_span", 64'(rcyc[7] - rcyc[0]), 7);
    chk("full_rate_d7", 64'(rdat[7]), 64'hC7);

    // Burst running off the end of the RAM
    wbuf[0] = 32'h5A5A_5A5A;
    wr_burst(BASE, 0, BURST_INCR, 4'hF, resp);
    wbuf[0] = 32'hD0; wbuf[1] = 32'hD1;
    wr_burst(BASE + 32'h3FC, 1, BURST_INCR, 4'hF, resp);
    chk("oor_bresp", 64'(resp), 64'(SLVERR));
    rd_burst(BASE + 32'h3FC, 1, BURST_INCR, 1'b0);
    chk("oor_d0", 64'(rdat[0]), 64'hD0);
    chk("oor_r0", 64'(rrsp[0]), 64'(OKAY));
    chk("oor_d1", 64'(rdat[1]), 0);
    chk("oor_r1", 64'(rrsp[1]), 64'(SLVERR));
    rd_burst(BASE, 0, BURST_INCR, 1'b0);
    chk("oor_no_alias", 64'(rdat[0]), 64'h5A5A_5A5A);

    // Reset during beat 2 of a len=7 read
    @(negedge clk);
    bus.arid = 4'h9; bus.araddr = BASE + 32'h80; bus.arlen = 8'd7;
    bus.arsize = 3'd2; bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    beat = 0; n = 0;
    while (beat < 2 && n < 50) begin
      if (bus.rvalid) beat++;
      @(negedge clk);
      n++;
    end
    chk("mid_beat2", 64'(bus.rdata), 64'hC2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rvalid", 64'(bus.rvalid), 0);
    chk("mid_arready_rst", 64'(bus.arready), 0);
    rst = 1'b0;
    bus.rready = 1'b0;
    chk("mid_arready_rel", 64'(bus.arready), 0);
    @(negedge clk);
    chk("mid_arready_up", 64'(bus.arready), 1);
    rd_burst(BASE + 32'h80, 1, BURST_INCR, 1'b0);
    chk("mid_keep0", 64'(rdat[0]), 64'hC0);
    chk("mid_keep1", 64'(rdat[1]), 64'hC1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_bram_slave.md
# axi_bram_slave

Parametrised AXI4 slave that embeds a byte-enabled, read-first dual-port block RAM. It is the next-generation memory slave on the SoC interconnect and replaces fixed-width, strobe-ignoring RAM slaves. Depth, width, ID width and base address are configurable. It adds byte-strobe writes, FIXED/INCR/WRAP burst addressing, SLVERR reporting and full-throughput read bursts under back-pressure. The read and write channels run independently and in parallel.

## Interface
Parameters:
- DATA_WIDTH, 32: data bus width in bits; power of two, 32..256.
- ADDR_WIDTH, 32: AXI address width.
- ID_BITS, 4: AXI ID width.
- LEN_BITS, 8: burst length field width.
- DEPTH, 4096: RAM depth in DATA_WIDTH words; power of two.
- BASE_ADDR, 0: byte address of word 0; aligned to DEPTH*DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock. All logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- AW channel: awid/awaddr/awlen/awsize/awburst/awvalid in, awready out. Widths are ID_BITS/ADDR_WIDTH/LEN_BITS/3/2/1.
- W channel: wdata (DATA_WIDTH), wstrb (DATA_WIDTH/8), wlast, wvalid in; wready out.
- B channel: bid (ID_BITS), bresp (2), bvalid out; bready in.
- AR channel: arid/araddr/arlen/arsize/arburst/arvalid in, arready out.
- R channel: rid, rdata, rresp, rlast, rvalid out; rready in.

## Operation
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). The address is in range when 0 <= index < DEPTH.
- Burst address sequence per AXI4:
  - FIXED holds the address.
  - INCR adds 2^size.
  - WRAP wraps at a (len+1)*2^size boundary.
- Whole-burst SLVERR cases: size > log2(DATA_WIDTH/8); burst = 2'b11; WRAP with len not in {1,3,7,15}.
- Per-beat SLVERR case: an out-of-range beat. The write is suppressed and read data is 0.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst, then go to W_DATA.
  - W_DATA: wready=1. Each beat writes the bytes enabled by wstrb. The beat counter runs to awlen. After the final beat, go to W_RESP.
  - W_RESP: bvalid=1 and bid = latched id. On bready, go to W_IDLE.
- bresp is OKAY unless any beat erred or wlast mismatched the beat count; either case gives SLVERR. Extra beats after the counted last beat are not accepted until the next AW.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, go to R_BURST.
  - R_BURST: RAM reads are issued into a 2-entry skid FIFO. A read is issued only when the FIFO is guaranteed space at data return.
  - rlast is asserted on beat arlen. When the last beat handshakes, go to R_IDLE.
  - rresp is per beat.
- Narrow transfers: reads return the full word; the master selects the lanes.
- Same-cycle read and write to one word: the read returns the old data (read-first).

## Timing
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0. bresp/rresp/bid/rid/rdata are 0. FSMs enter IDLE; awready and arready rise 1 cycle after rst_i deasserts.
- Reset mid-burst abandons the burst with no B or R response. RAM contents are not cleared.
- Write: first W beat accepted the cycle after the AW handshake. bvalid is asserted the cycle after the last W handshake.
- Read: first rvalid 2 cycles after the AR handshake (address register plus 1-cycle RAM). Beats follow back-to-back while rready=1.
- rready low: rvalid and rdata are held stable. No beat is lost or duplicated, and throughput recovers 1 cycle after rready rises.
- Next AW/AR is accepted only in IDLE. This gives one outstanding transaction per direction.

## Configuration
- AXI_BRAM_WRAP_EN defined: WRAP bursts are supported as above.
- Not defined: any WRAP burst gets whole-burst SLVERR. Writes are suppressed, reads return 0, and the wrap-address logic is removed.

## Structure
- Package axi_bram_pkg holds:
  - the burst-type enum (FIXED/INCR/WRAP)
  - resp constants OKAY=2'b00 and SLVERR=2'b10
  - the write and read FSM state enums
  - a next_addr(addr,len,size,burst) function
- Sub-module axi_bram_mem: a dual-port RAM with a per-byte write enable and a registered read-first output.

## Test plan
- INCR len=3, size=2, addr=BASE+0x10, data 0xA0..0xA3, then read back → 4 beats 0xA0..0xA3 with rlast on beat 3. bresp and rresp are OKAY.
- Write 0x11223344 with wstrb=4'b0101 over a word holding 0xFFFFFFFF → readback 0xFF22FF44.
- WRAP len=3, size=2, addr=BASE+0x18 → words accessed in order 0x18, 0x1C, 0x10, 0x14. Without the macro, bresp=SLVERR and no write occurs.
- Read len=7 with rready toggling 1/0 every cycle → 8 distinct, correct beats with rdata stable while stalled. With rready held high, beats arrive 1 per cycle.
- INCR write len=1 starting at the last word → beat 0 written, beat 1 suppressed, bresp=SLVERR. A read of the same range gives rresp OKAY then SLVERR, with rdata 0 on the second beat.
- Assert rst_i during beat 2 of a len=7 read → rvalid=0 the next cycle and arready=1 one cycle after rst_i deasserts. Previously written data is intact.
